// File: rtl/jt12_pkg.sv
// Shared definitions for the JT12 register-write sequencer: FSM encoding,
// chip address-bit meanings and the optional command FIFO geometry.
package jt12_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ASEL,
    ST_AGAP,
    ST_DSEL,
    ST_DGAP,
    ST_WBUSY
  } state_t;

  localparam logic ADDR_SEL  = 1'b0;
  localparam logic ADDR_DATA = 1'b1;

  localparam int FIFO_DEPTH = 4;

  // Field order gives the 17-bit {port,reg,val} word stored in the FIFO.
  typedef struct packed {
    logic       port;
    logic [7:0] rnum;
    logic [7:0] val;
  } cmd_t;

endpackage

// File: rtl/jt12_wr_fifo.sv
// Small command FIFO holding {port,reg,val} words ahead of the write FSM.
// A push on a full FIFO is taken when a pop happens in the same cycle.
module jt12_wr_fifo
  import jt12_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  cmd_t din,
  output cmd_t dout,
  output logic full,
  output logic empty
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  cmd_t             mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/jt12_wr_seq.sv
// Sequences host register writes into the JT12 two-strobe bus protocol.
// Build option: define JT12_WR_FIFO_EN to put a 4-entry command FIFO in front.
module jt12_wr_seq
  import jt12_pkg::*;
#(
  parameter int TOUT_W = 8,
  parameter int GAP    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_port,
  input  logic [7:0] cmd_reg,
  input  logic [7:0] cmd_val,
  output logic [7:0] dout,
  output logic [1:0] addr,
  output logic       write,
  input  logic       busy,
  output logic       idle,
  output logic       timeout,
  input  logic       tout_clr
);

  localparam logic [TOUT_W-1:0] GAP_LAST = TOUT_W'(GAP - 1);
  localparam logic [TOUT_W-1:0] CNT_MAX  = '1;
  localparam logic [TOUT_W-1:0] IGNORE_N = TOUT_W'(2);

  state_t            state;
  state_t            state_next;
  logic [TOUT_W-1:0] cnt;
  logic              cur_port;
  logic [7:0]        cur_val;
  cmd_t              head;
  logic              have_cmd;
  logic              q_empty;
  logic              take;
  logic              wait_exit;
  logic              tout_event;

`ifdef JT12_WR_FIFO_EN
  // With a queue the next command can start straight out of the busy wait.
  localparam bit CHAIN = 1'b1;
  logic fifo_full;
  logic fifo_empty;
  cmd_t in_cmd;

  assign in_cmd = {cmd_port, cmd_reg, cmd_val};

  jt12_wr_fifo u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd_valid & cmd_ready),
    .pop   (take),
    .din   (in_cmd),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign cmd_ready = ~fifo_full;
  assign have_cmd  = ~fifo_empty;
  assign q_empty   = fifo_empty;
`else
  localparam bit CHAIN = 1'b0;
  assign head      = {cmd_port, cmd_reg, cmd_val};
  assign cmd_ready = (state == ST_IDLE);
  assign have_cmd  = cmd_valid;
  assign q_empty   = 1'b1;
`endif

  // The chip's busy flag lags the strobe, so the first two wait cycles ignore it.
  assign wait_exit  = ((cnt >= IGNORE_N) && !busy) || (cnt == CNT_MAX);
  assign tout_event = (state == ST_WBUSY) && busy && (cnt == CNT_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    take       = 1'b0;
    case (state)
      ST_IDLE:  if (have_cmd) begin
                  state_next = ST_ASEL;
                  take       = 1'b1;
                end
      ST_ASEL:  state_next = ST_AGAP;
      ST_AGAP:  if (cnt == GAP_LAST) state_next = ST_DSEL;
      ST_DSEL:  state_next = ST_DGAP;
      ST_DGAP:  if (cnt == GAP_LAST) state_next = ST_WBUSY;
      ST_WBUSY: if (wait_exit) begin
                  if (CHAIN && have_cmd) begin
                    state_next = ST_ASEL;
                    take       = 1'b1;
                  end else begin
                    state_next = ST_IDLE;
                  end
                end
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    write = 1'b0;
    idle  = 1'b0;
    case (state)
      ST_ASEL, ST_DSEL: write = 1'b1;
      ST_IDLE:          idle  = q_empty;
      default:          ;
    endcase
  end

  // One counter times both the strobe gaps and the busy wait; it restarts on every state change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                          cnt <= '0;
    else if (state_next != state || state == ST_IDLE) cnt <= '0;
    else                                              cnt <= cnt + 1'b1;
  end

  // Bus values load only on the edge that raises write, so they hold through each strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr     <= '0;
      dout     <= '0;
      cur_port <= 1'b0;
      cur_val  <= '0;
    end else if (take) begin
      addr     <= {head.port, ADDR_SEL};
      dout     <= head.rnum;
      cur_port <= head.port;
      cur_val  <= head.val;
    end else if (state == ST_AGAP && state_next == ST_DSEL) begin
      addr <= {cur_port, ADDR_DATA};
      dout <= cur_val;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             timeout <= 1'b0;
    else if (tout_event) timeout <= 1'b1;
    else if (tout_clr)   timeout <= 1'b0;
  end

endmodule

// File: tb/tb_jt12_wr_seq.sv
// Bench for jt12_wr_seq: directed scenarios plus random traffic against a
// timeline model that tracks each command by cycles elapsed since its first strobe.
module tb_jt12_wr_seq;
  import jt12_pkg::*;

  localparam int TOUT_W = 8;
  localparam int GAP    = 1;
  localparam int WMAX   = (1 << TOUT_W) - 1;
  localparam int TW     = 2 * GAP + 2;
`ifdef JT12_WR_FIFO_EN
  localparam int OFF  = 1;
  localparam bit FIFO = 1'b1;
`else
  localparam int OFF  = 0;
  localparam bit FIFO = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_port;
  logic [7:0] cmd_reg;
  logic [7:0] cmd_val;
  logic [7:0] dout;
  logic [1:0] addr;
  logic       write;
  logic       busy;
  logic       idle;
  logic       timeout;
  logic       tout_clr;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  jt12_wr_seq #(.TOUT_W(TOUT_W), .GAP(GAP)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_port  (cmd_port),
    .cmd_reg   (cmd_reg),
    .cmd_val   (cmd_val),
    .dout      (dout),
    .addr      (addr),
    .write     (write),
    .busy      (busy),
    .idle      (idle),
    .timeout   (timeout),
    .tout_clr  (tout_clr)
  );

  // Model: queue of pending commands plus the active command's elapsed cycle count.
  logic [16:0] mq [$];
  bit          m_active;
  int          m_t;
  logic        m_port;
  logic [7:0]  m_val;
  logic [1:0]  m_addr;
  logic [7:0]  m_dout;
  bit          m_tout;
  logic [7:0]  data_seen [$];

  function automatic bit m_ready();
    return FIFO ? (mq.size() < FIFO_DEPTH) : !m_active;
  endfunction

  task automatic start_cmd(input logic [16:0] c);
    m_active = 1'b1;
    m_t      = 0;
    m_port   = c[16];
    m_val    = c[7:0];
    m_addr   = {c[16], 1'b0};
    m_dout   = c[15:8];
  endtask

  task automatic model_step();
    bit acc;
    bit done;
    bit tev;
    int k;
    acc  = cmd_valid && m_ready();
    done = 1'b0;
    tev  = 1'b0;
    if (m_active) begin
      if (m_t >= TW) begin
        k = m_t - TW;
        if (k >= 2 && !busy) done = 1'b1;
        else if (k == WMAX) begin
          done = 1'b1;
          tev  = 1'b1;
        end
      end
      if (!done) begin
        m_t++;
        if (m_t == GAP + 1) begin
          m_addr = {m_port, 1'b1};
          m_dout = m_val;
        end
      end
    end
    if (tev) m_tout = 1'b1;
    else if (tout_clr) m_tout = 1'b0;
    if (FIFO) begin
      if ((!m_active || done) && mq.size() > 0) start_cmd(mq.pop_front());
      else if (done) m_active = 1'b0;
      if (acc) mq.push_back({cmd_port, cmd_reg, cmd_val});
    end else begin
      if (done) m_active = 1'b0;
      else if (acc) start_cmd({cmd_port, cmd_reg, cmd_val});
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_active = 1'b0;
      m_t      = 0;
      m_addr   = '0;
      m_dout   = '0;
      m_tout   = 1'b0;
    end else begin
      model_step();
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Compare process: DUT against the model every cycle, plus strobe-shape properties.
  initial begin
    logic       pw;
    logic       mw;
    logic [1:0] sa;
    logic [7:0] sd;
    pw = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      sa = addr;
      sd = dout;
      @(negedge clk);
      mw = m_active && (m_t == 0 || m_t == GAP + 1);
      checkOutput("write", write, mw);
      checkOutput("addr", addr, m_addr);
      checkOutput("dout", dout, m_dout);
      checkOutput("idle", idle, !m_active && mq.size() == 0);
      checkOutput("cmd_ready", cmd_ready, m_ready());
      checkOutput("timeout", timeout, m_tout);
      checkOutput("no_adjacent_strobes", write & pw, 0);
      if (mw && !rst) begin
        checkOutput("addr_stable_in_strobe", sa, m_addr);
        checkOutput("dout_stable_in_strobe", sd, m_dout);
      end
      if (write && addr[0] && !rst) data_seen.push_back(dout);
      pw = rst ? 1'b0 : write;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no completion expected finish before 2000000");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic p, input logic [7:0] r, input logic [7:0] d);
    cmd_valid = v;
    cmd_port  = p;
    cmd_reg   = r;
    cmd_val   = d;
  endtask

  initial begin
    int  nd;
    int  nf;
    int  te;
    int  blen;
    bit  drop;
    rst = 1'b1;
    busy = 1'b0;
    tout_clr = 1'b0;
    applyStimulus(0, 0, 8'h00, 8'h00);
    tick();
    checkOutput("rst_write", write, 0);
    checkOutput("rst_addr", addr, 0);
    checkOutput("rst_dout", dout, 0);
    checkOutput("rst_idle", idle, 1);
    checkOutput("rst_timeout", timeout, 0);
    checkOutput("rst_ready", cmd_ready, 1);
    tick();
    rst = 1'b0;
    tick();

    // Scenario 1: single write, busy low; WBUSY lasts 3 cycles before idle.
    applyStimulus(1, 0, 8'h28, 8'hF1);
    tick();
    cmd_valid = 1'b0;
    for (int n = 1; n <= 8 + OFF; n++) begin
      checkOutput("s1_write", write, (n == 1 + OFF) || (n == 3 + OFF));
      checkOutput("s1_idle", idle, n == 8 + OFF);
      if (n == 1 + OFF) begin
        checkOutput("s1_addr_sel", addr, 2'd0);
        checkOutput("s1_dout_reg", dout, 8'h28);
      end
      if (n == 3 + OFF) begin
        checkOutput("s1_addr_data", addr, 2'd1);
        checkOutput("s1_dout_val", dout, 8'hF1);
      end
      tick();
    end

    // Scenario 2: port 1, busy held 20 cycles from the data strobe, second command waiting.
    applyStimulus(1, 1, 8'hA4, 8'h22);
    tick();
    cmd_valid = 1'b0;
    nd = 3 + OFF;
    nf = FIFO ? 0 : 1;
    for (int n = 1; n <= nd + 23; n++) begin
      busy = (n >= nd) && (n < nd + 20);
      if (n == 5 + OFF) applyStimulus(1, 0, 8'h11, 8'h5A);
      if (n == 1 + OFF) begin
        checkOutput("s2_addr_sel", addr, 2'd2);
        checkOutput("s2_dout_reg", dout, 8'hA4);
      end
      if (n == nd) begin
        checkOutput("s2_addr_data", addr, 2'd3);
        checkOutput("s2_dout_val", dout, 8'h22);
      end
      if (n > nd) checkOutput("s2_write", write, n == nd + 21 + nf);
      if (n == nd + 20) checkOutput("s2_idle_in_wait", idle, 0);
      if (n == nd + 21 + nf) begin
        checkOutput("s2_next_addr", addr, 2'd0);
        checkOutput("s2_next_dout", dout, 8'h11);
      end
      drop = cmd_valid && cmd_ready;
      tick();
      if (drop) cmd_valid = 1'b0;
    end
    busy = 1'b0;
    repeat (10) tick();

    // Scenario 3: busy stuck high; the event falls in the WBUSY cycle with counter all-ones.
    te = 5 + OFF + WMAX;
    busy = 1'b1;
    applyStimulus(1, 0, 8'h2B, 8'h80);
    tick();
    cmd_valid = 1'b0;
    repeat (te - 1) tick();
    checkOutput("s3_tout_before", timeout, 0);
    checkOutput("s3_idle_before", idle, 0);
    tick();
    checkOutput("s3_tout_set", timeout, 1);
    checkOutput("s3_idle_after", idle, 1);
    tout_clr = 1'b1;
    tick();
    tout_clr = 1'b0;
    checkOutput("s3_tout_cleared", timeout, 0);
    applyStimulus(1, 1, 8'h2C, 8'h81);
    tick();
    cmd_valid = 1'b0;
    repeat (te - 1) tick();
    tout_clr = 1'b1;
    checkOutput("s3_tout_before_race", timeout, 0);
    tick();
    tout_clr = 1'b0;
    checkOutput("s3_set_wins", timeout, 1);
    busy = 1'b0;
    tout_clr = 1'b1;
    tick();
    tout_clr = 1'b0;
    repeat (3) tick();

`ifdef JT12_WR_FIFO_EN
    // Scenario 4: back-to-back commands fill the FIFO; order must be preserved.
    data_seen.delete();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, i[0], 8'(8'h30 + i), 8'(8'hC0 + i));
      checkOutput("s4_ready", cmd_ready, i < 5);
      tick();
    end
    for (int w = 0; w < 50 && !cmd_ready; w++) tick();
    checkOutput("s4_ready_returns", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    repeat (80) tick();
    checkOutput("s4_count", data_seen.size(), 6);
    for (int i = 0; i < 6 && i < data_seen.size(); i++) checkOutput("s4_order", data_seen[i], 8'hC0 + i);
`endif

    // Scenario 5: reset during a strobe drops write at once; reset in the gap leaves no strobe.
    applyStimulus(1, 0, 8'h55, 8'h66);
    tick();
    cmd_valid = 1'b0;
    repeat (OFF) tick();
    checkOutput("s5_write_before", write, 1);
    #1 rst = 1'b1;
    #1 checkOutput("s5_write_async", write, 0);
    checkOutput("s5_addr_async", addr, 0);
    tick();
    rst = 1'b0;
    checkOutput("s5_idle_after", idle, 1);
    applyStimulus(1, 1, 8'h56, 8'h67);
    tick();
    cmd_valid = 1'b0;
    repeat (1 + OFF) tick();
    #1 rst = 1'b1;
    #1 checkOutput("s5_gap_write", write, 0);
    checkOutput("s5_gap_idle", idle, 1);
    tick();
    rst = 1'b0;
    for (int n = 0; n < 12; n++) begin
      checkOutput("s5_no_residual", write, 0);
      tick();
    end

    // Random traffic, busy bursts (occasionally long enough to time out), clears and resets.
    blen = 0;
    for (int c = 0; c < 3000; c++) begin
      applyStimulus($urandom_range(0, 99) < 40, 1'($urandom), 8'($urandom), 8'($urandom));
      if (blen > 0) begin
        busy = 1'b1;
        blen--;
      end else begin
        busy = 1'b0;
        if ($urandom_range(0, 9) == 0) blen = ($urandom_range(0, 59) == 0) ? 300 : $urandom_range(1, 25);
      end
      tout_clr = ($urandom_range(0, 49) == 0);
      rst = ($urandom_range(0, 1499) == 0);
      tick();
    end
    rst = 1'b0;
    busy = 1'b0;
    tout_clr = 1'b0;
    cmd_valid = 1'b0;
    repeat (5) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
